// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_capture
// Description : Observes a time-multiplexed, active-low 7-segment display bus
//               and recovers the hex nibble, decimal point and validity of
//               each digit position. A per-select stability filter keeps
//               digit-switching ghosts from being captured.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_capture #(
  parameter  int NDIG   = 4,
  parameter  int STABLE = 3,
  localparam int IW     = (NDIG > 1) ? $clog2(NDIG) : 1,
  localparam int CW     = $clog2(STABLE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NDIG-1:0]   sel_n,
  input  logic [7:0]        seg,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   err,
  output logic [NDIG-1:0]   dp,
  output logic              upd,
  output logic [IW-1:0]     upd_idx
);

  // Active-low segment pattern (g..a) to {match, nibble}
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1111000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0010000: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b0000011: r = 5'h1B;
      7'b1000110: r = 5'h1C;
      7'b0100001: r = 5'h1D;
      7'b0000110: r = 5'h1E;
      7'b0001110: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [NDIG-1:0] samp_sel;
  logic [7:0]      samp_seg;
  logic [CW-1:0]   cnt;
  logic            hit;

  logic [NDIG-1:0] sel_low;
  logic            legal;
  logic            same;
  logic [CW-1:0]   cnt_nxt;
  logic            hit_nxt;
  logic [IW-1:0]   cap_idx;
  logic [4:0]      dec;
  logic            blank;

  // Legality of the live sample, comparison with the previous sample, and
  // the next counter value. A capture is armed only on the transition into
  // saturation so a held pattern is captured exactly once.
  always_comb begin
    sel_low = ~sel_n;
    legal   = (sel_low != '0) && ((sel_low & (sel_low - 1'b1)) == '0);
    same    = (sel_n == samp_sel) && (seg == samp_seg);
    cnt_nxt = '0;
    hit_nxt = 1'b0;
    if (legal) begin
      if (same) begin
        cnt_nxt = (cnt == CW'(STABLE)) ? cnt : cnt + CW'(1);
        hit_nxt = (cnt == CW'(STABLE - 1));
      end else begin
        cnt_nxt = CW'(1);
        hit_nxt = (STABLE == 1);
      end
    end
  end

  // Digit index and decode of the held sample being captured
  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!samp_sel[i]) cap_idx = IW'(i);
    end
    dec   = decode(samp_seg[6:0]);
    blank = (samp_seg[6:0] == 7'b1111111);
  end

  // Input sample register, stability counter and capture strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_sel <= '1;
      samp_seg <= '1;
      cnt      <= '0;
      hit      <= 1'b0;
    end else begin
      samp_sel <= sel_n;
      samp_seg <= seg;
      cnt      <= cnt_nxt;
      hit      <= hit_nxt;
    end
  end

  // Per-digit result registers and update pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits  <= '0;
      valid   <= '0;
      err     <= '0;
      dp      <= '0;
      upd     <= 1'b0;
      upd_idx <= '0;
    end else begin
      upd <= hit;
      if (hit) begin
        upd_idx <= cap_idx;
        for (int i = 0; i < NDIG; i++) begin
          if (cap_idx == IW'(i)) begin
            dp[i] <= ~samp_seg[7];
            if (dec[4]) begin
              digits[4*i +: 4] <= dec[3:0];
              valid[i]         <= 1'b1;
              err[i]           <= 1'b0;
            end else begin
              valid[i] <= 1'b0;
              err[i]   <= ~blank;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
